// File: rtl/cluster_frame_builder_pkg.sv
// cluster_frame_builder_pkg
// Shared definitions for the cluster frame builder: address width, the
// encoder's "no cluster" code, bunch-crossing wrap point, the frame state
// enum and the 22-bit address pair carried per clock4x cycle.
`timescale 1ns/1ps
package cluster_frame_builder_pkg;

  localparam int ADR_W = 11;
  localparam int BXN_W = 12;
  localparam logic [ADR_W-1:0] INVALID_ADR = 11'h7FF;
  localparam logic [BXN_W-1:0] BX_MAX      = 12'd3563;

  // IDLE: no frame on the link; E0..E3: emitting pair 0..3 of a frame.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    E0   = 3'd1,
    E1   = 3'd2,
    E2   = 3'd3,
    E3   = 3'd4
  } frame_state_e;

  typedef struct packed {
    logic [ADR_W-1:0] hi;
    logic [ADR_W-1:0] lo;
  } frame_pair_t;

endpackage

// File: rtl/cluster_frame_builder_bx_counter.sv
// bx_counter
// 12-bit bunch-crossing counter, advanced only on the bx0 strobe.
// bc0 (orbit reset) loads zero; otherwise the count wraps from BX_MAX to 0.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bx0         bunch-crossing strobe (advance enable)
//   bc0         orbit reset, only meaningful together with bx0
//   bxn_upd     value the counter takes on this bx0; the frame captured on
//               the same strobe is tagged with it
`timescale 1ns/1ps
module bx_counter
  import cluster_frame_builder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bx0,
  input  logic             bc0,
  output logic [BXN_W-1:0] bxn_upd
);

  logic [BXN_W-1:0] bxn;

  always_comb begin
    bxn_upd = bxn + 12'd1;
    if (bc0 || (bxn == BX_MAX)) bxn_upd = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bxn <= '0;
    end else if (bx0) begin
      bxn <= bxn_upd;
    end
  end

endmodule

// File: rtl/cluster_frame_builder.sv
// cluster_frame_builder
// Latches the encoder's eight cluster addresses on each bx0 strobe, tags
// them with the bunch-crossing number and serialises them as four
// {adr_hi, adr_lo} pairs on consecutive clock4x cycles. Frames with no
// valid address are suppressed; a strobe arriving before the current frame
// reached its last pair aborts that frame and sets the sticky sync_err.
//
// Handshake: there is no backpressure. frame_valid=1 means frame_data holds
// a pair this cycle; frame_sof marks the first pair of a frame. The
// consumer must accept every valid cycle.
//
// Ports:
//   clock4x, global_reset_n  160 MHz clock, asynchronous active-low reset
//   bx0, bc0                 bunch-crossing strobe, orbit reset (with bx0)
//   adr0..adr7               encoder addresses, adr0 highest priority
//   frame_data               {adr_hi, adr_lo} pair of the current cycle
//   frame_valid, frame_sof   pair valid, first pair of frame
//   frame_bxn, frame_nvalid  BX number and valid-address count, held
//   sync_err                 sticky strobe misalignment flag
//   full_frames              (FULL_FRAME_COUNT_EN only) saturating count of
//                            captured frames with all eight addresses valid
//
// Build option: define FULL_FRAME_COUNT_EN to add the full_frames counter.
`timescale 1ns/1ps
module cluster_frame_builder
  import cluster_frame_builder_pkg::*;
(
  input  logic               clock4x,
  input  logic               global_reset_n,
  input  logic               bx0,
  input  logic               bc0,
  input  logic [ADR_W-1:0]   adr0,
  input  logic [ADR_W-1:0]   adr1,
  input  logic [ADR_W-1:0]   adr2,
  input  logic [ADR_W-1:0]   adr3,
  input  logic [ADR_W-1:0]   adr4,
  input  logic [ADR_W-1:0]   adr5,
  input  logic [ADR_W-1:0]   adr6,
  input  logic [ADR_W-1:0]   adr7,
  output logic [2*ADR_W-1:0] frame_data,
  output logic               frame_valid,
  output logic               frame_sof,
  output logic [BXN_W-1:0]   frame_bxn,
  output logic [3:0]         frame_nvalid,
  output logic               sync_err
`ifdef FULL_FRAME_COUNT_EN
  ,
  output logic [15:0]        full_frames
`endif
);

  logic [ADR_W-1:0] adr_in [8];
  logic [ADR_W-1:0] hold   [8];
  logic [3:0]       nvalid;
  logic [BXN_W-1:0] bxn_upd;
  frame_state_e     state;
  frame_pair_t      pair;

  assign adr_in[0] = adr0;
  assign adr_in[1] = adr1;
  assign adr_in[2] = adr2;
  assign adr_in[3] = adr3;
  assign adr_in[4] = adr4;
  assign adr_in[5] = adr5;
  assign adr_in[6] = adr6;
  assign adr_in[7] = adr7;

  bx_counter u_bx_counter (
    .clk     (clock4x),
    .rst_n   (global_reset_n),
    .bx0     (bx0),
    .bc0     (bc0),
    .bxn_upd (bxn_upd)
  );

  // Number of real clusters on the encoder outputs this cycle.
  always_comb begin
    nvalid = '0;
    for (int i = 0; i < 8; i++) begin
      if (adr_in[i] != INVALID_ADR) nvalid = nvalid + 4'd1;
    end
  end

  // Frame state machine. A bx0 always wins: it captures new data from any
  // state, and only IDLE/E3 are legal places for it to arrive.
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state        <= IDLE;
      frame_valid  <= 1'b0;
      frame_sof    <= 1'b0;
      frame_bxn    <= '0;
      frame_nvalid <= '0;
      sync_err     <= 1'b0;
      for (int i = 0; i < 8; i++) hold[i] <= INVALID_ADR;
    end else if (bx0) begin
      for (int i = 0; i < 8; i++) hold[i] <= adr_in[i];
      frame_bxn    <= bxn_upd;
      frame_nvalid <= nvalid;
      if (state inside {E0, E1, E2}) sync_err <= 1'b1;
      if (nvalid != 4'd0) begin
        state       <= E0;
        frame_valid <= 1'b1;
        frame_sof   <= 1'b1;
      end else begin
        state       <= IDLE;
        frame_valid <= 1'b0;
        frame_sof   <= 1'b0;
      end
    end else begin
      frame_sof <= 1'b0;
      case (state)
        E0: begin
          state       <= E1;
          frame_valid <= 1'b1;
        end
        E1: begin
          state       <= E2;
          frame_valid <= 1'b1;
        end
        E2: begin
          state       <= E3;
          frame_valid <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          frame_valid <= 1'b0;
        end
      endcase
    end
  end

  // Pair selection decodes the registered state straight from the hold
  // registers, so it changes on the same edge as the state and is forced to
  // zero the moment reset asserts.
  always_comb begin
    pair = '0;
    case (state)
      E0:      pair = '{hi: hold[1], lo: hold[0]};
      E1:      pair = '{hi: hold[3], lo: hold[2]};
      E2:      pair = '{hi: hold[5], lo: hold[4]};
      E3:      pair = '{hi: hold[7], lo: hold[6]};
      default: pair = '0;
    endcase
  end

  assign frame_data = pair;

`ifdef FULL_FRAME_COUNT_EN
  // Frames with all eight slots used hint at clusters lost upstream.
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      full_frames <= '0;
    end else if (bx0 && (nvalid == 4'd8) && (full_frames != 16'hFFFF)) begin
      full_frames <= full_frames + 16'd1;
    end
  end
`endif

endmodule
